// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simon_pkg
// Description : Shared types and constants for the Simon Says round
//               controller: FSM state enumeration, display message codes and
//               the pattern LFSR feedback taps with its step function.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package simon_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_READY    = 4'd1,
    ST_SET      = 4'd2,
    ST_GO       = 4'd3,
    ST_PLAY_ON  = 4'd4,
    ST_PLAY_OFF = 4'd5,
    ST_INPUT    = 4'd6,
    ST_WIN      = 4'd7,
    ST_LOSE     = 4'd8
  } state_t;

  // Message codes understood by the seven-segment display driver.
  localparam logic [2:0] DISP_IDLE  = 3'd0;
  localparam logic [2:0] DISP_READY = 3'd1;
  localparam logic [2:0] DISP_SET   = 3'd2;
  localparam logic [2:0] DISP_GO    = 3'd3;
  localparam logic [2:0] DISP_PLAY  = 3'd4;
  localparam logic [2:0] DISP_INPUT = 3'd5;
  localparam logic [2:0] DISP_WIN   = 3'd6;
  localparam logic [2:0] DISP_LOSE  = 3'd7;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5;
  // the XOR of those bits is shifted in at bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Timebase divider. Emits a single-cycle tick every DIV clock
//               cycles; clr restarts the count so the next tick is a full
//               DIV cycles away.
// Ports       : clk   - system clock
//               reset - asynchronous active-high reset
//               clr   - zero the divider counter
//               tick  - one-cycle pulse every DIV cycles
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + ONE;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/simon_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : simon_round_ctrl
// Description : Simon Says game-round controller. Runs the ready/set/go
//               countdown, plays back the growing random pattern on four
//               LEDs and checks the player's presses against it.
// Ports       : clk   - system clock
//               reset - asynchronous active-high reset
//               go    - start request (honoured in IDLE, WIN, LOSE)
//               btn   - debounced single-cycle button pulses
//               led   - one-hot pattern playback
//               disp  - message code for the display driver
//               level - current pattern length
//               busy  - high while a game is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 100_000_000,
  parameter int unsigned RSG_TICKS     = 1,
  parameter int unsigned ON_TICKS      = 1,
  parameter int unsigned OFF_TICKS     = 1,
  parameter int unsigned TIMEOUT_TICKS = 5,
  parameter int unsigned MAX_LEN       = 16,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         go,
  input  logic [3:0]                   btn,
  output logic [3:0]                   led,
  output logic [2:0]                   disp,
  output logic [$clog2(MAX_LEN+1)-1:0] level,
  output logic                         busy
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  // Tick counter only has to reach the longest per-state duration.
  localparam int unsigned MAX_A = (RSG_TICKS > ON_TICKS) ? RSG_TICKS : ON_TICKS;
  localparam int unsigned MAX_B = (OFF_TICKS > TIMEOUT_TICKS) ? OFF_TICKS : TIMEOUT_TICKS;
  localparam int unsigned MAXT  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TW    = $clog2(MAXT + 1);

  localparam logic [TW-1:0] T_RSG  = TW'(RSG_TICKS - 1);
  localparam logic [TW-1:0] T_ON   = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] T_OFF  = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] T_TOUT = TW'(TIMEOUT_TICKS - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [LW-1:0] L_ONE  = LW'(1);
  localparam logic [LW-1:0] L_MAX  = LW'(MAX_LEN);

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [1:0]    pat_q [MAX_LEN];
  logic          pat_we;
  logic [IW-1:0] pat_waddr;
  logic          tick;
  logic          clr;
  logic [1:0]    cur_pat;
  logic [3:0]    cur_onehot;
  logic          last_idx;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  assign cur_pat    = pat_q[idx_q[IW-1:0]];
  assign cur_onehot = 4'b0001 << cur_pat;
  assign last_idx   = (idx_q == (len_q - L_ONE));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    tcnt_d    = tick ? (tcnt_q + T_ONE) : tcnt_q;
    pat_we    = 1'b0;
    pat_waddr = '0;
    clr       = 1'b0;

    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (go) begin
          state_d   = ST_READY;
          len_d     = L_ONE;
          idx_d     = '0;
          pat_we    = 1'b1;
          pat_waddr = '0;
        end
      end
      ST_READY:    if (tick && tcnt_q == T_RSG) state_d = ST_SET;
      ST_SET:      if (tick && tcnt_q == T_RSG) state_d = ST_GO;
      ST_GO:       if (tick && tcnt_q == T_RSG) state_d = ST_PLAY_ON;
      ST_PLAY_ON:  if (tick && tcnt_q == T_ON)  state_d = ST_PLAY_OFF;
      ST_PLAY_OFF: begin
        if (tick && tcnt_q == T_OFF) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = ST_INPUT;
          end else begin
            idx_d   = idx_q + L_ONE;
            state_d = ST_PLAY_ON;
          end
        end
      end
      ST_INPUT: begin
        // A press takes priority over a timeout expiring in the same cycle.
        if (btn != 4'b0000) begin
          if (btn == cur_onehot) begin
            if (!last_idx) begin
              idx_d  = idx_q + L_ONE;
              clr    = 1'b1;
              tcnt_d = '0;
            end else if (len_q == L_MAX) begin
              state_d = ST_WIN;
            end else begin
              pat_we    = 1'b1;
              pat_waddr = len_q[IW-1:0];
              len_d     = len_q + L_ONE;
              idx_d     = '0;
              state_d   = ST_READY;
            end
          end else begin
            state_d = ST_LOSE;
          end
        end else if (tick && tcnt_q == T_TOUT) begin
          state_d = ST_LOSE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every state starts with a fresh divider and tick count.
    if (state_d != state_q) begin
      clr    = 1'b1;
      tcnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED;
      len_q   <= '0;
      idx_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_next(lfsr_q);
      len_q   <= len_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Pattern contents are meaningless after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (pat_we) begin
      pat_q[pat_waddr] <= lfsr_q[1:0];
    end
  end

  assign led   = (state_q == ST_PLAY_ON) ? cur_onehot : 4'b0000;
  assign level = len_q;
  assign busy  = !(state_q == ST_IDLE || state_q == ST_WIN || state_q == ST_LOSE);

  always_comb begin
    disp = DISP_IDLE;
    case (state_q)
      ST_READY:                disp = DISP_READY;
      ST_SET:                  disp = DISP_SET;
      ST_GO:                   disp = DISP_GO;
      ST_PLAY_ON, ST_PLAY_OFF: disp = DISP_PLAY;
      ST_INPUT:                disp = DISP_INPUT;
      ST_WIN:                  disp = DISP_WIN;
      ST_LOSE:                 disp = DISP_LOSE;
      default:                 disp = DISP_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_simon_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_simon_round_ctrl
// Description : Self-checking bench for simon_round_ctrl. Expected display,
//               LED, level and busy values come from the game rules and the
//               timing constants; the pattern is predicted from an LFSR model
//               indexed by the number of clock edges since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_round_ctrl;

  localparam int          TD   = 4;
  localparam int          RSG  = 2;
  localparam int          ON   = 2;
  localparam int          OFF  = 1;
  localparam int          TO   = 8;
  localparam int          ML   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       go    = 1'b0;
  logic [3:0] btn   = 4'b0000;
  logic [3:0] led;
  logic [2:0] disp;
  logic [1:0] level;
  logic       busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [1:0] exp_pat [ML];
  int         exp_len = 0;

  simon_round_ctrl #(
    .TICK_DIV      (TD),
    .RSG_TICKS     (RSG),
    .ON_TICKS      (ON),
    .OFF_TICKS     (OFF),
    .TIMEOUT_TICKS (TO),
    .MAX_LEN       (ML),
    .SEED          (SEED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .btn   (btn),
    .led   (led),
    .disp  (disp),
    .level (level),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset was released: the LFSR has advanced this often.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1);
  end

  // x^16+x^14+x^13+x^11 sequence, right-shifting form, from SEED after n steps.
  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] v;
    logic        b;
    v = SEED;
    for (int i = 0; i < n; i++) begin
      b = v[0] ^ v[2] ^ v[3] ^ v[5];
      v = {b, v[15:1]};
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] d, input logic [3:0] l,
                         input logic [1:0] lv, input logic b);
    chk({tag, ".disp"},  {5'd0, disp},  {5'd0, d});
    chk({tag, ".led"},   {4'd0, led},   {4'd0, l});
    chk({tag, ".level"}, {6'd0, level}, {6'd0, lv});
    chk({tag, ".busy"},  {7'd0, busy},  {7'd0, b});
  endtask

  // n cycles of constant outputs; noise drives go and random buttons, both
  // of which must be ignored while playback is running.
  task automatic span(input string tag, input logic [2:0] d, input logic [3:0] l,
                      input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      chk_all(tag, d, l, 2'(exp_len), 1'b1);
      if (noise) begin
        go  = 1'b1;
        btn = 4'($urandom_range(1, 15));
      end
      step();
    end
    go  = 1'b0;
    btn = 4'b0000;
  endtask

  task automatic play_round(input bit noise);
    span("ready", 3'd1, 4'd0, RSG * TD, 1'b0);
    span("set",   3'd2, 4'd0, RSG * TD, 1'b0);
    span("go",    3'd3, 4'd0, RSG * TD, 1'b0);
    for (int j = 0; j < exp_len; j++) begin
      span("on",  3'd4, 4'b0001 << exp_pat[j], ON * TD, noise);
      span("off", 3'd4, 4'd0, OFF * TD, 1'b0);
    end
    chk_all("input", 3'd5, 4'd0, 2'(exp_len), 1'b1);
  endtask

  task automatic start(input string tag);
    logic [15:0] v;
    v          = lfsr_at(cyc);
    exp_pat[0] = v[1:0];
    exp_len    = 1;
    go         = 1'b1;
    step();
    go         = 1'b0;
    chk_all(tag, 3'd1, 4'd0, 2'd1, 1'b1);
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    step();
    btn = 4'b0000;
  endtask

  // Correct press of the final pattern entry below MAX_LEN: pattern grows.
  task automatic press_grow();
    logic [15:0] v;
    v = lfsr_at(cyc);
    press(4'b0001 << exp_pat[exp_len-1]);
    exp_pat[exp_len] = v[1:0];
    exp_len++;
    chk_all("grow", 3'd1, 4'd0, 2'(exp_len), 1'b1);
  endtask

  initial begin
    logic [1:0] w;

    // Reset and long idle.
    repeat (3) @(negedge clk);
    chk_all("in_reset", 3'd0, 4'd0, 2'd0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk_all("idle", 3'd0, 4'd0, 2'd0, 1'b0);
      step();
    end
    repeat ($urandom_range(0, 15)) step();

    // Full game to WIN, with ignored go/btn during playback of round two.
    start("start1");
    play_round(1'b0);
    press_grow();
    play_round(1'b1);
    press(4'b0001 << exp_pat[0]);
    chk_all("idx1", 3'd5, 4'd0, 2'd2, 1'b1);
    press(4'b0001 << exp_pat[1]);
    for (int i = 0; i < 5; i++) begin
      chk_all("win", 3'd6, 4'd0, 2'd2, 1'b0);
      step();
    end

    // go in WIN, then wrong single-bit press.
    start("start_from_win");
    play_round(1'b0);
    w = exp_pat[0] + 2'($urandom_range(1, 3));
    press(4'b0001 << w);
    chk_all("wrong", 3'd7, 4'd0, 2'd1, 1'b0);
    repeat ($urandom_range(1, 10)) step();

    // go in LOSE, then a two-button press.
    start("start_from_lose");
    play_round(1'b0);
    press(4'b0011);
    chk_all("multi", 3'd7, 4'd0, 2'd1, 1'b0);

    // Timeout window: a press on the expiry edge wins, then a full silent
    // window of TO*TD cycles loses.
    start("start_tout");
    play_round(1'b0);
    press_grow();
    play_round(1'b0);
    for (int i = 1; i < TO * TD; i++) begin
      step();
      chk_all("wait1", 3'd5, 4'd0, 2'd2, 1'b1);
    end
    press(4'b0001 << exp_pat[0]);
    chk_all("press_at_expiry", 3'd5, 4'd0, 2'd2, 1'b1);
    for (int i = 1; i < TO * TD; i++) begin
      step();
      chk_all("wait2", 3'd5, 4'd0, 2'd2, 1'b1);
    end
    step();
    chk_all("timeout", 3'd7, 4'd0, 2'd2, 1'b0);

    // Asynchronous reset in the middle of PLAY_ON.
    start("start_rst");
    span("ready", 3'd1, 4'd0, RSG * TD, 1'b0);
    span("set",   3'd2, 4'd0, RSG * TD, 1'b0);
    span("go",    3'd3, 4'd0, RSG * TD, 1'b0);
    span("on",    3'd4, 4'b0001 << exp_pat[0], 3, 1'b0);
    chk_all("on_before_rst", 3'd4, 4'b0001 << exp_pat[0], 2'd1, 1'b1);
    #2 reset = 1'b1;
    #1 chk_all("async_reset", 3'd0, 4'd0, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk_all("after_reset", 3'd0, 4'd0, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/simon_round_ctrl.md
# simon_round_ctrl

Game-round controller for the Simon Says board. It sequences the ready/set/go countdown, plays back the growing random pattern on the four LEDs, then collects and checks the player's button presses. It sits between the debounced button/`go` inputs and the seven-segment display driver and LED outputs. It tells the display driver what to show through a message code and a level count; it does not drive the display itself.

## Interface
Parameters:
- `TICK_DIV`, default 100_000_000: clock cycles per timing tick (1 s at 100 MHz). Benches use small values.
- `RSG_TICKS`, default 1: ticks spent in each of READY, SET and GO.
- `ON_TICKS`, default 1: ticks each pattern LED is lit.
- `OFF_TICKS`, default 1: ticks of dark gap after each pattern LED.
- `TIMEOUT_TICKS`, default 5: maximum ticks allowed between player presses.
- `MAX_LEN`, default 16: pattern length that wins the game.
- `SEED`, default 16'hACE1: LFSR reset value. Must be non-zero.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `go`, in, 1: start request, level-sampled on `clk`.
- `btn`, in, 4: player buttons. Already debounced; each press is a single-cycle pulse.
- `led`, out, 4: one-hot pattern playback.
- `disp`, out, 3: message code for the display driver.
- `level`, out, $clog2(MAX_LEN+1): current pattern length.
- `busy`, out, 1: high while a game is in progress.

## Operation
- FSM states: IDLE, READY, SET, GO, PLAY_ON, PLAY_OFF, INPUT, WIN, LOSE.
- `disp` codes: IDLE=0 ("----"), READY=1 ("rdY"), SET=2 ("SEt"), GO=3 ("Go"), PLAY_ON/PLAY_OFF=4 (shows level), INPUT=5, WIN=6 ("PASS"), LOSE=7 ("FAIL").
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-running; advances every clock from `SEED`.
- Pattern storage: `MAX_LEN` x 2-bit register array `pat`, plus `len` (`level` = `len`).
- Entering a game: IDLE, WIN or LOSE with `go`=1 moves to READY.
  - On that transition: `len`<=1, `pat[0]`<=`lfsr[1:0]`.
- Countdown: READY -> SET -> GO -> PLAY_ON. Each state lasts `RSG_TICKS` ticks.
- Playback: index `idx` starts at 0.
  - PLAY_ON drives `led` = 1<<`pat[idx]` for `ON_TICKS` ticks, then moves to PLAY_OFF.
  - PLAY_OFF holds `led`=0 for `OFF_TICKS` ticks. Then `idx`++ and return to PLAY_ON, or, if `idx`==`len`-1, set `idx`<=0 and go to INPUT.
- INPUT: any cycle with `btn`!=0 is a press.
  - Press equal to 1<<`pat[idx]`: correct.
    - If `idx`<`len`-1: `idx`++ and restart the timeout.
    - Else if `len`==`MAX_LEN`: go to WIN.
    - Else: `pat[len]`<=`lfsr[1:0]`, `len`++, go to READY.
  - Any other non-zero value, including multiple bits set: go to LOSE.
  - No press for `TIMEOUT_TICKS` ticks: go to LOSE.
- WIN/LOSE: `level` holds its final value until the next `go`.
- `busy` = 0 in IDLE, WIN and LOSE; 1 otherwise.
- Ignored inputs:
  - `btn` outside INPUT.
  - `go` outside IDLE, WIN and LOSE.
- `led` is 0 in every state except PLAY_ON.

## Timing
- All outputs are registered, or decoded from registered state only. Output changes appear on the clock edge of the state change.
- Reset values: state=IDLE, `led`=0, `disp`=0, `level`=0, `busy`=0, `idx`=0, LFSR=`SEED`, tick divider=0.
- `reset` takes effect immediately, at any point, including mid-playback or mid-input. It has no effect on `pat` contents, which are don't-care after reset.
- Tick divider is cleared on every state transition and on every correct press in INPUT.
  - Consequence: a state with N ticks lasts exactly N*`TICK_DIV` cycles.
  - Consequence: the timeout window is exactly `TIMEOUT_TICKS`*`TICK_DIV` cycles after entering INPUT or after the last correct press.
- `go` high on edge k in IDLE gives `disp`=1 from edge k onward.
- Press and timeout expiry in the same cycle: the press wins.
- Press in the last cycle of INPUT moves the FSM on the following edge. No press is lost.

## Structure
- Shared package `simon_pkg` holds:
  - the state enumeration;
  - the `disp` code constants;
  - the LFSR tap constant.
- Sub-module `tick_gen`:
  - parameter `DIV`; ports `clk`, `reset`, `clr`, `tick`;
  - emits a single-cycle `tick` every `DIV` cycles;
  - `clr` zeroes its counter.
- The controller itself counts ticks within a state.

## Test plan
Bench parameters: `TICK_DIV`=4, `RSG_TICKS`=2, `ON_TICKS`=2, `OFF_TICKS`=1, `TIMEOUT_TICKS`=8, `MAX_LEN`=2.

1. Reset pulse, then `go`=0 for 100 cycles -> `led`=0, `disp`=0, `level`=0, `busy`=0 throughout.
2. `go` high for one edge -> `disp` sequence is 1 for 8 cycles, 2 for 8, 3 for 8. Then 4 with `led`=1<<`pat[0]` for 8 cycles and `led`=0 for 4. Then `disp`=5. `level`=1, `busy`=1.
3. Correct presses through both rounds -> `level` 1 -> 2, second countdown plays two LEDs, final correct press gives `disp`=6, `busy`=0, `level`=2.
4. Variants:
   - wrong single-bit press in INPUT -> `disp`=7 next edge, `level` unchanged;
   - `btn`=4'b0011 -> `disp`=7.
5. No press for 32 cycles in INPUT -> LOSE on cycle 32. A correct press at cycle 31 keeps the FSM in INPUT and restarts the window.
6. Edge cases:
   - `reset` asserted during PLAY_ON -> `led`=0, `disp`=0 immediately, without waiting for a clock;
   - `go` in LOSE -> READY with `level`=1;
   - `go` during PLAY_ON -> no effect.
